// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the serializer family.
// Holds the shift FSM encoding and the bit-counter width function.
package piso_serializer_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Never returns 0, so a counter for N=2 still has one bit
   function automatic int piso_clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle of the serializer.
// The master side supplies words; the slave side is the serializer itself.
interface piso_serializer_if #(
   parameter int N = 8
);
   logic         din_valid;
   logic         din_ready;
   logic [N-1:0] din;
   logic         dout;
   logic         dout_valid;
   logic         sof;
   logic         eof;

   modport master (
      output din_valid, din,
      input  din_ready, dout, dout_valid, sof, eof
   );

   modport slave (
      input  din_valid, din,
      output din_ready, dout, dout_valid, sof, eof
   );
endinterface

// File: rtl/piso_bit_counter.sv
// Enabled modulo-N bit index counter with a registered terminal-count flag.
// Shared between the serializer and the matching deserializer.
module piso_bit_counter
   import piso_serializer_pkg::*;
#(
   parameter  int N     = 8,
   localparam int CNT_W = piso_clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             tc_r;

   // Next index: wrap to zero after the last bit, otherwise step by one
   always_comb begin
      cnt_s = cnt_r;
      if (en) begin
         if (cnt_r == LAST) begin
            cnt_s = {CNT_W{1'b0}};
         end else begin
            cnt_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Counter and terminal-count registers; tc tracks cnt_r == LAST exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
         tc_r  <= 1'b0;
      end else begin
         cnt_r <= cnt_s;
         tc_r  <= (cnt_s == LAST);
      end
   end

   assign cnt = cnt_r;
   assign tc  = tc_r;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter with valid/ready input and sof/eof markers.
// A new word may load on the last bit of the current frame, giving a gapless stream.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int   N          = 8,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   piso_serializer_if.slave bus
);

   localparam int CNT_W = piso_clog2(N);

   state_t           state_r, state_s;
   logic [N-1:0]     shreg_r, shreg_s;
   logic             dout_r, dout_s;
   logic             dout_valid_r, dout_valid_s;
   logic             sof_r, sof_s;
   logic             eof_r, eof_s;
   logic [CNT_W-1:0] cnt_s;
   logic             tc_s;
   logic             ready_s;
   logic             accept_s;
   logic             first_bit_s;

   // The counter only advances while shifting; leaving SHIFT wraps it back to 0
   piso_bit_counter #(.N(N)) u_bit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ena && (state_r == ST_SHIFT)),
      .cnt   (cnt_s),
      .tc    (tc_s)
   );

   assign ready_s       = ena && ((state_r == ST_IDLE) || tc_s);
   assign accept_s      = ready_s && bus.din_valid;
   assign first_bit_s   = MSB_FIRST ? bus.din[N-1] : bus.din[0];
   assign bus.din_ready = ready_s;

   // Next-state and next-output logic; everything holds while ena is low
   always_comb begin
      state_s      = state_r;
      shreg_s      = shreg_r;
      dout_s       = dout_r;
      dout_valid_s = dout_valid_r;
      sof_s        = sof_r;
      eof_s        = eof_r;
      if (!ena) begin
         state_s = state_r;
      end else if (accept_s) begin
         state_s      = ST_SHIFT;
         shreg_s      = bus.din;
         dout_s       = first_bit_s;
         dout_valid_s = 1'b1;
         sof_s        = 1'b1;
         eof_s        = 1'b0;
      end else begin
         case (state_r)
            ST_SHIFT: begin
               if (!tc_s) begin
                  shreg_s = MSB_FIRST ? {shreg_r[N-2:0], 1'b0} : {1'b0, shreg_r[N-1:1]};
                  dout_s  = MSB_FIRST ? shreg_r[N-2] : shreg_r[1];
                  sof_s   = 1'b0;
                  eof_s   = (cnt_s == CNT_W'(N - 2));
               end else begin
                  state_s      = ST_IDLE;
                  dout_s       = IDLE_LEVEL;
                  dout_valid_s = 1'b0;
                  sof_s        = 1'b0;
                  eof_s        = 1'b0;
               end
            end
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s      = ST_IDLE;
               dout_s       = IDLE_LEVEL;
               dout_valid_s = 1'b0;
               sof_s        = 1'b0;
               eof_s        = 1'b0;
            end
         endcase
      end
   end

   // State and registered serial outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         shreg_r      <= {N{1'b0}};
         dout_r       <= IDLE_LEVEL;
         dout_valid_r <= 1'b0;
         sof_r        <= 1'b0;
         eof_r        <= 1'b0;
      end else begin
         state_r      <= state_s;
         shreg_r      <= shreg_s;
         dout_r       <= dout_s;
         dout_valid_r <= dout_valid_s;
         sof_r        <= sof_s;
         eof_r        <= eof_s;
      end
   end

   assign bus.dout       = dout_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.sof        = sof_r;
   assign bus.eof        = eof_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: an MSB-first (idle 0) and an LSB-first (idle 1) N=4 serializer share
// one stimulus stream; each accepted word queues its expected bits for both instances.
module tb_piso_serializer;

   typedef struct packed {
      logic dout;
      logic valid;
      logic sof;
      logic eof;
   } ent_t;

   typedef struct packed {
      ent_t m;
      ent_t l;
   } pair_t;

   localparam pair_t IDLE_P = {4'b0000, 4'b1000};

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       din_valid;
   logic [3:0] din;
   logic       rand_ena;

   pair_t q[$];
   pair_t exp_r;
   int    n_checks;
   int    n_fail;

   piso_serializer_if #(.N(4)) bus_m ();
   piso_serializer_if #(.N(4)) bus_l ();

   assign bus_m.din_valid = din_valid;
   assign bus_m.din       = din;
   assign bus_l.din_valid = din_valid;
   assign bus_l.din       = din;

   piso_serializer #(.N(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus_m)
   );

   piso_serializer #(.N(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic got, input logic exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected stream: a word is taken when the queue is empty (idle or last bit showing)
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         exp_r <= IDLE_P;
      end else if (ena) begin
         if ((q.size() == 0) && din_valid) begin
            for (int i = 0; i < 4; i++) begin
               q.push_back({din[3-i], 1'b1, (i == 0), (i == 3),
                            din[i],   1'b1, (i == 0), (i == 3)});
            end
         end
         if (q.size() != 0) begin
            exp_r <= q.pop_front();
         end else begin
            exp_r <= IDLE_P;
         end
      end
   end

   // Compare both instances every cycle, away from the active edge
   always @(negedge clk) begin
      check_eq("m_dout",  bus_m.dout,       exp_r.m.dout);
      check_eq("m_valid", bus_m.dout_valid, exp_r.m.valid);
      check_eq("m_sof",   bus_m.sof,        exp_r.m.sof);
      check_eq("m_eof",   bus_m.eof,        exp_r.m.eof);
      check_eq("l_dout",  bus_l.dout,       exp_r.l.dout);
      check_eq("l_valid", bus_l.dout_valid, exp_r.l.valid);
      check_eq("l_sof",   bus_l.sof,        exp_r.l.sof);
      check_eq("l_eof",   bus_l.eof,        exp_r.l.eof);
      check_eq("m_ready", bus_m.din_ready,  ena && (q.size() == 0));
      check_eq("l_ready", bus_l.din_ready,  ena && (q.size() == 0));
   end

   task automatic drive_word(input logic [3:0] w);
      logic acc;
      acc       = 1'b0;
      din_valid = 1'b1;
      din       = w;
      for (int k = 0; (k < 40) && !acc; k++) begin
         if (rand_ena) ena = ($urandom_range(0, 3) != 0);
         acc = ena && (q.size() == 0);
         @(posedge clk);
         #1;
      end
      check_eq("accept_timeout", acc, 1'b1);
      din_valid = 1'b0;
      din       = 4'($urandom());
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (rand_ena) ena = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b1;
      ena       = 1'b1;
      din_valid = 1'b0;
      din       = 4'b0000;
      rand_ena  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_m_dout",  bus_m.dout,       1'b0);
      check_eq("rst_m_valid", bus_m.dout_valid, 1'b0);
      check_eq("rst_m_sof",   bus_m.sof,        1'b0);
      check_eq("rst_m_eof",   bus_m.eof,        1'b0);
      check_eq("rst_l_dout",  bus_l.dout,       1'b1);
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word, then idle
      drive_word(4'b1011);
      idle(6);

      // Back-to-back frames with din_valid held
      drive_word(4'b1011);
      drive_word(4'b0110);
      idle(6);

      // Stall after bit 1 while a second word waits
      drive_word(4'b1011);
      idle(1);
      ena       = 1'b0;
      din_valid = 1'b1;
      din       = 4'b0101;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      ena = 1'b1;
      drive_word(4'b0101);
      idle(6);

      // Word presented while the previous frame is mid-shift
      drive_word(4'b1111);
      idle(1);
      drive_word(4'b0001);
      idle(6);

      // Reset in the middle of a frame
      drive_word(4'b1011);
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_m_dout",  bus_m.dout,       1'b0);
      check_eq("mid_rst_m_valid", bus_m.dout_valid, 1'b0);
      check_eq("mid_rst_m_sof",   bus_m.sof,        1'b0);
      check_eq("mid_rst_m_eof",   bus_m.eof,        1'b0);
      check_eq("mid_rst_l_dout",  bus_l.dout,       1'b1);
      check_eq("mid_rst_l_valid", bus_l.dout_valid, 1'b0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("ready_after_rst", bus_m.din_ready, 1'b1);
      drive_word(4'b0110);
      idle(6);

      // Random words with random enable gaps
      rand_ena = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive_word(4'($urandom()));
         idle($urandom_range(0, 2));
      end
      rand_ena = 1'b0;
      ena      = 1'b1;
      idle(8);
      check_eq("drained", (q.size() == 0), 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parameterised parallel-in/serial-out converter with a valid/ready input handshake and frame markers on the serial side. It accepts an N-bit word and shifts it out one bit per enabled clock, MSB- or LSB-first. Back-to-back words produce a gapless bit stream. It sits between word-oriented datapath logic and single-bit serial links or test outputs.

Parameters:
N, 8, word width in bits; legal range N >= 2.
MSB_FIRST, 1, 1 = bit N-1 is sent first; 0 = bit 0 is sent first.
IDLE_LEVEL, 1'b0, Dout level whenever no frame is active.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
ena  in  1  clock enable; when low, all state, outputs and handshakes freeze.
din_valid  in  1  Din holds a word to transfer.
din_ready  out  1  block accepts Din this cycle (combinational).
Din  in  N  parallel input word.
Dout  out  1  serial data (registered).
dout_valid  out  1  Dout carries a frame bit (registered).
sof  out  1  high with the first bit of each frame (registered).
eof  out  1  high with the last bit of each frame (registered).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, shreg=0.
  - Dout=IDLE_LEVEL, dout_valid=0, sof=0, eof=0.
  - Effective immediately, not on the next edge. A frame in progress is aborted and its remaining bits are discarded.
- States: IDLE, SHIFT. cnt is clog2(N) bits wide and holds the index of the bit currently on Dout (0..N-1).
- Accept: a word transfers on an edge where din_valid && din_ready.
  - din_ready = ena && (state==IDLE || cnt==N-1).
  - din_ready is never high while ena=0.
- IDLE, accept at edge k:
  - Dout <= first bit, dout_valid <= 1, sof <= 1, eof <= 0.
  - cnt <= 0; shreg <= Din; state <= SHIFT.
  - The first bit is visible after edge k, giving one cycle of latency.
- SHIFT, ena=1, cnt < N-1:
  - Dout <= next bit; cnt <= cnt+1; sof <= 0.
  - eof <= (cnt+1 == N-1).
- SHIFT, ena=1, cnt == N-1:
  - If din_valid: load the new word exactly as in IDLE, with no gap bit. eof <= 0, sof <= 1.
  - Else: state <= IDLE, dout_valid <= 0, Dout <= IDLE_LEVEL, sof <= 0, eof <= 0.
- ena=0: every register holds. Dout, dout_valid, sof and eof stay stable for as many cycles as ena stays low.
- Bit order:
  - MSB_FIRST=1 sends Din[N-1] down to Din[0].
  - MSB_FIRST=0 sends Din[0] up to Din[N-1].
- Din is sampled only at the accept edge; later changes to Din do not affect the frame in flight.
- din_valid asserted while din_ready=0 is ignored. Upstream must hold the word until it is accepted.
- Each frame is exactly N dout_valid cycles (counting enabled cycles only). sof and eof are never high together, since N >= 2.

Decomposition:
- Shared package: state enum (IDLE, SHIFT) and a clog2 constant function for the cnt width.
- Optional sub-module piso_bit_counter: enabled, wrapping modulo-N counter with a terminal-count flag (cnt==N-1). It is reused by the later SIPO block.
- The shift/select logic stays in the top module.

Test Plan:
- Single word, N=4, MSB_FIRST=1: Din=4'b1011 accepted at edge 1 -> Dout=1,0,1,1 after edges 1-4. sof high only with the first bit, eof high only with the last. dout_valid=0 and Dout=IDLE_LEVEL from edge 5.
- Back-to-back: 4'b1011 then 4'b0110 with din_valid held -> 8 contiguous bits 1,0,1,1,0,1,1,0. din_ready high only in the cnt==3 cycle of frame 1. sof at bits 0 and 4, eof at bits 3 and 7.
- LSB-first instance, N=4: Din=4'b1011 -> Dout=1,1,0,1.
- ena=0 for 3 cycles after bit 1 of 4'b1011 -> Dout holds 0 and dout_valid stays 1 for 3 cycles, then continues 1,1. din_ready stays low throughout the stall.
- Busy input: present 4'b0001 with din_valid while frame 4'b1111 is mid-shift -> word accepted only on the cnt==3 cycle, and output order is 1111 followed by 0001.
- Reset mid-frame: assert rst_n=0 after 2 bits of 4'b1011 -> Dout=IDLE_LEVEL and dout_valid/sof/eof=0 immediately. After release, din_ready=1 when ena=1, and the next word shifts out cleanly from sof.
